// File: rtl/nand_seq_alu.sv
// nand_seq_alu: a multi-cycle bitwise logic unit. One shared WIDTH-bit NAND
// stage is time-multiplexed by a micro-sequencer to build
// NAND/AND/OR/NOR/XOR/XNOR. It does one NAND evaluation per clock, and the
// requester uses a start/done handshake.
module nand_seq_alu #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       steps
);

    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
    typedef enum logic [2:0] {SRC_A, SRC_B, SRC_W1, SRC_W2, SRC_W3, SRC_W4} src_t;
    typedef enum logic [2:0] {DST_W1, DST_W2, DST_W3, DST_W4, DST_Y} dst_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [2:0]       s_q;
    logic [WIDTH-1:0] w1_q, w2_q, w3_q, w4_q;

    src_t             x_sel_c, z_sel_c;
    dst_t             dst_c;
    logic             illegal_c;
    logic             last_c;
    logic             accept_c;
    logic [WIDTH-1:0] x_c, z_c, nand_c;

    // Micro-program ROM: (op, step) selects both NAND inputs and the destination.
    always_comb begin
        x_sel_c   = SRC_A;
        z_sel_c   = SRC_B;
        dst_c     = DST_Y;
        illegal_c = 1'b0;
        case (op_q)
            OP_NAND: begin
                dst_c = DST_Y;
            end
            OP_AND: begin
                case (s_q)
                    3'd0:    dst_c = DST_W1;
                    default: begin x_sel_c = SRC_W1; z_sel_c = SRC_W1; dst_c = DST_Y; end
                endcase
            end
            OP_OR, OP_NOR: begin
                case (s_q)
                    3'd0: begin x_sel_c = SRC_A; z_sel_c = SRC_A; dst_c = DST_W1; end
                    3'd1: begin x_sel_c = SRC_B; z_sel_c = SRC_B; dst_c = DST_W2; end
                    3'd2: begin
                        x_sel_c = SRC_W1;
                        z_sel_c = SRC_W2;
                        dst_c   = (op_q == OP_OR) ? DST_Y : DST_W3;
                    end
                    default: begin x_sel_c = SRC_W3; z_sel_c = SRC_W3; dst_c = DST_Y; end
                endcase
            end
            OP_XOR, OP_XNOR: begin
                case (s_q)
                    3'd0: begin x_sel_c = SRC_A; z_sel_c = SRC_B;  dst_c = DST_W1; end
                    3'd1: begin x_sel_c = SRC_A; z_sel_c = SRC_W1; dst_c = DST_W2; end
                    3'd2: begin x_sel_c = SRC_B; z_sel_c = SRC_W1; dst_c = DST_W3; end
                    3'd3: begin
                        x_sel_c = SRC_W2;
                        z_sel_c = SRC_W3;
                        dst_c   = (op_q == OP_XOR) ? DST_Y : DST_W4;
                    end
                    default: begin x_sel_c = SRC_W4; z_sel_c = SRC_W4; dst_c = DST_Y; end
                endcase
            end
            default: begin
                illegal_c = 1'b1;
            end
        endcase
    end

    // The final step of a program (or an illegal op) is the last EXEC cycle.
    assign last_c = illegal_c || (dst_c == DST_Y);

    // Operand muxes feeding the single shared NAND stage.
    always_comb begin
        x_c = a_q;
        z_c = b_q;
        case (x_sel_c)
            SRC_A:   x_c = a_q;
            SRC_B:   x_c = b_q;
            SRC_W1:  x_c = w1_q;
            SRC_W2:  x_c = w2_q;
            SRC_W3:  x_c = w3_q;
            SRC_W4:  x_c = w4_q;
            default: x_c = a_q;
        endcase
        case (z_sel_c)
            SRC_A:   z_c = a_q;
            SRC_B:   z_c = b_q;
            SRC_W1:  z_c = w1_q;
            SRC_W2:  z_c = w2_q;
            SRC_W3:  z_c = w3_q;
            SRC_W4:  z_c = w4_q;
            default: z_c = b_q;
        endcase
    end

    assign nand_c = ~(x_c & z_c);

    // Next-state logic: accepts requests in IDLE or DONE, ignores them in EXEC.
    always_comb begin
        state_n  = state_q;
        accept_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_n  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (last_c) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                if (start) begin
                    accept_c = 1'b1;
                    state_n  = ST_EXEC;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Operand latch, step counter, scratch writes and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            s_q   <= '0;
            w1_q  <= '0;
            w2_q  <= '0;
            w3_q  <= '0;
            w4_q  <= '0;
            y     <= '0;
            err   <= 1'b0;
            steps <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_n == ST_EXEC);
            done <= (state_n == ST_DONE);
            if (accept_c) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
                s_q  <= '0;
                err  <= 1'b0;
            end else if (state_q == ST_EXEC) begin
                if (illegal_c) begin
                    y     <= '0;
                    err   <= 1'b1;
                    steps <= '0;
                end else begin
                    case (dst_c)
                        DST_W1:  w1_q <= nand_c;
                        DST_W2:  w2_q <= nand_c;
                        DST_W3:  w3_q <= nand_c;
                        DST_W4:  w4_q <= nand_c;
                        default: y    <= nand_c;
                    endcase
                    if (last_c) begin
                        steps <= s_q + 3'd1;
                    end else begin
                        s_q <= s_q + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/nand_seq_alu.md
Name: nand_seq_alu

Overview:
- Multi-cycle bitwise logic unit with one shared WIDTH-bit NAND stage and a small scratch register file.
- A micro-sequencer time-multiplexes that single NAND stage to build NAND/AND/OR/NOR/XOR/XNOR, issuing one NAND evaluation per clock.
- Sits between a requester using a start/done handshake and the universal-gate datapath.
- Exists so gate-count-minimal NAND-only logic is realised as a controlled, schedulable resource.

Parameters:
- WIDTH, 4, operand/result bit width; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  3  0=NAND 1=AND 2=OR 3=NOR 4=XOR 5=XNOR 6,7=illegal
- a  input  WIDTH  operand A, latched when start is accepted
- b  input  WIDTH  operand B, latched when start is accepted
- y  output  WIDTH  registered result; holds until the next completion
- busy  output  1  high while the micro-sequence executes
- done  output  1  one-cycle completion pulse
- err  output  1  high with done if op was illegal; holds until the next accept
- steps  output  3  NAND evaluations used by the last operation

Behaviour:
- Reset (rst=1 at a clock edge): y=0, busy=0, done=0, err=0, steps=0, state=IDLE, scratch w1..w4=0. Reset overrides everything, including mid-sequence; the in-flight operation is discarded and no done is produced.
- States:
  - IDLE: waiting for a request.
  - EXEC: one NAND per cycle, with step index s counting from 0.
  - DONE: a one-cycle state in which done=1.
- Accept: start=1 and state is IDLE or DONE → latch a, b, op into internal registers; s=0; state=EXEC; err cleared. Back-to-back requests are accepted in the DONE cycle.
- start in EXEC is ignored; there is no queueing.
- Datapath per EXEC cycle: exactly one evaluation dst = ~(x & z), with x, z and dst selected by (op, s). Nothing else touches the NAND.
- Micro-programs (each step is one cycle; the final step writes y):
  - NAND: y=n(a,b); S=1
  - AND: w1=n(a,b); y=n(w1,w1); S=2
  - OR: w1=n(a,a); w2=n(b,b); y=n(w1,w2); S=3
  - NOR: the OR sequence into w3, then y=n(w3,w3); S=4
  - XOR: w1=n(a,b); w2=n(a,w1); w3=n(b,w1); y=n(w2,w3); S=4
  - XNOR: the XOR sequence into w4, then y=n(w4,w4); S=5
- Illegal op (6/7): no NAND evaluation. EXEC lasts 1 cycle, then y=0, err=1, steps=0.
- Latency: start is sampled at the end of cycle 0. busy=1 in cycles 1..S (1 for illegal). y and steps update at the end of cycle S. done=1 and busy=0 in cycle S+1. The next accept is possible in cycle S+1.
- The DONE state falls to IDLE after one cycle if there is no start.
- busy and done are never high together.
- y changes only at completion or reset. Latched operands are immune to a/b changes during EXEC.
- All logic is bitwise: no carries, and no width growth.

Test Plan:
- Reset check: assert rst for 2 cycles with random inputs → y=0, busy=0, done=0, err=0, steps=0.
- Full op sweep, WIDTH=4, a=4'b1100, b=4'b1010, ops 0..5 → y = 0111, 1000, 1110, 0001, 0110, 1001; steps = 1, 2, 3, 4, 4, 5; done arrives exactly S+1 cycles after start.
- Illegal op: op=6, a=4'hF, b=4'hF → busy for 1 cycle, then done=1, err=1, y=0, steps=0. A following legal AND clears err.
- Operand immunity and busy ignore:
  - Start XNOR with a=4'b0000, b=4'b0000; during busy drive start=1, op=0, a=b=4'hF.
  - Required: result y=4'b1111 after 5 steps, and the second request is not executed.
- Back-to-back: hold start=1 continuously alternating AND/OR on a=4'b0101, b=4'b0011 → done pulses separated by 3 and 4 cycles; y=0001 then 0111.
- Mid-operation reset: rst=1 in step 2 of an XOR → no done pulse, y stays 0, and the next NAND request completes normally with y=~(a&b).
